i2c_eeprom_slave: RTL and testbench

Synthesisable, parametrised I2C serial-EEPROM slave (24Cxx-style) for the EEPROM test environment, clocked by the system clock.
- Oversamples SCL/SDA and decodes START/STOP.
- Supports byte write, page write with in-page wrap, current/random/sequential read, and ACK polling during an internal write cycle.
- Provides an open-drain SDA drive. The pad tri-state lives outside this block.

---
 rtl/i2c_eeprom_slave_pkg.sv | 24 ++
 rtl/i2c_eeprom_slave_bus_sync.sv | 36 +++
 rtl/i2c_eeprom_slave.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_eeprom_slave_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the I2C EEPROM slave: FSM states, device-type default,
// R/W bit position and the bus levels that mean ACK / NACK.
package i2c_eeprom_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CTRL      = 4'd1,
    ST_CTRL_ACK  = 4'd2,
    ST_ADDR      = 4'd3,
    ST_ADDR_ACK  = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  localparam logic [3:0] DEV_ID_DEFAULT = 4'b1010;
  localparam int         RW_BIT         = 0;
  localparam logic       SDA_ACK        = 1'b0;
  localparam logic       SDA_NACK       = 1'b1;

endpackage

// File: rtl/i2c_eeprom_slave_bus_sync.sv
`timescale 1ns/1ps
// SCL/SDA synchroniser with one history stage; emits scl edges and START/STOP,
// each usable by the consumer three clk after the pad change.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] form the synchroniser, [2] is the previous filtered value.
  logic [2:0] scl_sh;
  logic [2:0] sda_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sh <= '1;
      sda_sh <= '1;
    end else begin
      scl_sh <= {scl_sh[1:0], scl_i};
      sda_sh <= {sda_sh[1:0], sda_i};
    end
  end

  assign sda       = sda_sh[1];
  assign scl_rise  =  scl_sh[1] & ~scl_sh[2];
  assign scl_fall  = ~scl_sh[1] &  scl_sh[2];
  assign start_det =  scl_sh[1] &  scl_sh[2] &  sda_sh[2] & ~sda_sh[1];
  assign stop_det  =  scl_sh[1] &  scl_sh[2] & ~sda_sh[2] &  sda_sh[1];

endmodule

// File: rtl/i2c_eeprom_slave.sv
`timescale 1ns/1ps
// 24Cxx-style I2C EEPROM slave: byte/page write with in-page wrap, current/random/
// sequential read, ACK polling while the internal write cycle runs.
module i2c_eeprom_slave
  import i2c_eeprom_slave_pkg::*;
#(
  parameter int         ADDR_W     = 11,
  parameter int         ADDR_BYTES = 1,
  parameter int         PAGE_W     = 4,
  parameter logic [3:0] DEV_ID     = DEV_ID_DEFAULT,
  parameter int         WR_CYCLES  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic [3:0] state_o
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam int         AB8       = 8 * ADDR_BYTES;
  localparam int         CNT_W     = $clog2(WR_CYCLES + 1);
  localparam logic       LAST_ABYT = 1'(ADDR_BYTES - 1);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [7:0]        ctrl;
  logic [AB8-1:0]    addr_acc;
  logic              byte_idx;
  logic              ack_phase;
  logic              wrote;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  busy_cnt;
  logic [7:0]        mem [DEPTH];

  logic [7:0]        rx_byte, rd_byte;
  logic [ADDR_W-1:0] page_next;
  logic              byte_done, ctrl_ok, wr_byte;

  assign rx_byte   = {shreg[6:0], sda};
  assign rd_byte   = mem[ptr];
  assign page_next = {ptr[ADDR_W-1:PAGE_W], ptr[PAGE_W-1:0] + PAGE_W'(1)};
  assign byte_done = (bit_cnt == 4'd7);
  assign busy      = (busy_cnt != '0);
  assign ctrl_ok   = (ctrl[7:4] == DEV_ID) && !busy;
  assign wr_byte   = (state == ST_WDATA) && scl_rise && byte_done && !busy
                     && !start_det && !stop_det;
  assign state_o   = state;

  // NOTE: the array sits in its own reset-free block so it maps to RAM; resetting
  // it would force every word into flops.
  always_ff @(posedge clk) begin
    if (wr_byte) mem[ptr] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ctrl      <= '0;
      addr_acc  <= '0;
      byte_idx  <= 1'b0;
      ack_phase <= 1'b0;
      wrote     <= 1'b0;
      ptr       <= '0;
      busy_cnt  <= '0;
      sda_oe    <= 1'b0;
    end else begin
      if (busy) busy_cnt <= busy_cnt - CNT_W'(1);

      // Bus conditions outrank any scl edge seen in the same clk.
      if (start_det) begin
        state   <= ST_CTRL;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        wrote  <= 1'b0;
        if (wrote) busy_cnt <= CNT_W'(WR_CYCLES);
      end else begin
        case (state)
          ST_IDLE, ST_WAIT_STOP: begin
          end
          ST_CTRL, ST_ADDR, ST_WDATA: if (scl_rise) begin
            shreg <= rx_byte;
            if (!byte_done) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else begin
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
              if (state == ST_CTRL) begin
                ctrl  <= rx_byte;
                state <= ST_CTRL_ACK;
              end else if (state == ST_ADDR) begin
                addr_acc <= AB8'({addr_acc, rx_byte});
                state    <= ST_ADDR_ACK;
              end else begin
                if (wr_byte) begin
                  ptr   <= page_next;
                  wrote <= 1'b1;
                end
                state <= ST_WDATA_ACK;
              end
            end
          end
          // Ack states: first scl_fall drives the ACK, second one ends the slot.
          ST_CTRL_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= ctrl_ok;
              ack_phase <= 1'b1;
              if (!ctrl_ok) state <= ST_WAIT_STOP;
            end else begin
              bit_cnt <= '0;
              if (ctrl[RW_BIT]) begin
                shreg  <= rd_byte;
                sda_oe <= ~rd_byte[7];
                state  <= ST_RDATA;
              end else begin
                sda_oe   <= 1'b0;
                byte_idx <= 1'b0;
                state    <= ST_ADDR;
              end
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              if (byte_idx == LAST_ABYT) begin
                ptr   <= ADDR_W'({ctrl[3:1], addr_acc});
                state <= ST_WDATA;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                state    <= ST_ADDR;
              end
            end
          end
          ST_WDATA_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              state  <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe    <= 1'b0;
                ptr       <= ptr + ADDR_W'(1);
                ack_phase <= 1'b0;
                state     <= ST_RACK;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          ST_RACK: begin
            if (scl_rise) begin
              if (sda == SDA_ACK) ack_phase <= 1'b1;
              else                state     <= ST_WAIT_STOP;
            end else if (scl_fall && ack_phase) begin
              shreg   <= rd_byte;
              sda_oe  <= ~rd_byte[7];
              bit_cnt <= '0;
              state   <= ST_RDATA;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
`timescale 1ns/1ps
// Scoreboard bench for i2c_eeprom_slave: a bit-banged master records what the bus
// carried, a monitor process compares each record against the queued expectation.
module tb_i2c_eeprom_slave;
  import i2c_eeprom_slave_pkg::*;

  localparam int  WR_CYCLES = 5000;
  localparam time Q         = 40ns;

  logic       clk, rst, m_scl, m_sda;
  logic       sda_oe, busy;
  logic [3:0] state_o;
  wire        sda_line = m_sda & ~sda_oe;

  i2c_eeprom_slave #(
    .ADDR_W     (11),
    .ADDR_BYTES (1),
    .PAGE_W     (4),
    .DEV_ID     (4'b1010),
    .WR_CYCLES  (WR_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (m_scl),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    val;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];
  item_t mon_o, mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_val(input string name, input int v);
    item_t it;
    it.name = name;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic observe(input string name, input int v);
    item_t it;
    it.name = name;
    it.val  = v;
    obs_q.push_back(it);
  endtask

  // Monitor: pairs every bus observation with the oldest pending expectation.
  initial forever begin
    wait (obs_q.size() != 0);
    mon_o = obs_q.pop_front();
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected %s: got 0x%0h, expected nothing", mon_o.name, mon_o.val);
    end else begin
      mon_e = exp_q.pop_front();
      check({mon_e.name, "/", mon_o.name}, mon_o.val, mon_e.val);
    end
  end

  // Busy-width recorder: clk cycles busy stays high after each write cycle starts.
  initial forever begin
    int cnt;
    @(posedge busy);
    cnt = 0;
    while (busy && cnt < 20000) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    observe("busy_width", cnt);
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic tx(input logic [7:0] b, input logic exp_bit, input string name);
    logic ack;
    expect_val(name, int'(exp_bit));
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; #Q;
      m_scl = 1'b1; #(2*Q);
      m_scl = 1'b0; #Q;
    end
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    ack = sda_line; #Q;
    m_scl = 1'b0; #Q;
    observe(name, int'(ack));
  endtask

  task automatic rx(input logic [7:0] exp_b, input logic ack_lvl, input string name);
    logic [7:0] b;
    expect_val(name, int'(exp_b));
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q;
      m_scl = 1'b1; #Q;
      b[i] = sda_line; #Q;
      m_scl = 1'b0; #Q;
    end
    m_sda = ack_lvl; #Q;
    m_scl = 1'b1; #(2*Q);
    m_scl = 1'b0; #Q;
    observe(name, int'(b));
  endtask

  task automatic wait_not_busy();
    int k = 0;
    while (busy && k < 8000) begin
      @(negedge clk);
      k++;
    end
    check("busy_clear_timeout", int'(busy), 0);
  endtask

  // data holds up to four bytes, first byte in [31:24].
  task automatic write_txn(input logic [7:0] ctrl, input logic [7:0] addr,
                           input logic [31:0] data, input int n, input bit settle);
    i2c_start();
    tx(ctrl, SDA_ACK, "w_ctrl");
    tx(addr, SDA_ACK, "w_addr");
    for (int i = 0; i < n; i++) tx(data[31-8*i -: 8], SDA_ACK, "w_data");
    i2c_stop();
    if (settle) begin
      expect_val("busy_width", WR_CYCLES);
      wait_not_busy();
    end
  endtask

  task automatic rand_read(input logic [7:0] ctrl, input logic [7:0] addr,
                           input logic [31:0] data, input int n);
    i2c_start();
    tx(ctrl, SDA_ACK, "r_ctrl_w");
    tx(addr, SDA_ACK, "r_addr");
    i2c_start();
    tx(ctrl | 8'h01, SDA_ACK, "r_ctrl_r");
    for (int i = 0; i < n; i++)
      rx(data[31-8*i -: 8], (i < n - 1) ? SDA_ACK : SDA_NACK, "r_data");
    check("oe_after_nack", int'(sda_oe), 0);
    i2c_stop();
  endtask

  initial begin
    rst   = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_sda_oe", int'(sda_oe), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_state", int'(state_o), int'(ST_IDLE));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: byte write, busy window, read-back
    write_txn(8'hA0, 8'h05, 32'h3C00_0000, 1, 1'b1);
    rand_read(8'hA0, 8'h05, 32'h3C00_0000, 1);

    // 2: random read using page bits from the control byte (0x110)
    write_txn(8'hA2, 8'h10, 32'h5A00_0000, 1, 1'b1);
    rand_read(8'hA2, 8'h10, 32'h5A00_0000, 1);
    check("idle_after_read", int'(state_o), int'(ST_IDLE));
    check("oe_after_stop", int'(sda_oe), 0);

    // 3: page write wraps from 0x00F to 0x000
    write_txn(8'hA0, 8'h0E, 32'h1122_3344, 4, 1'b1);
    rand_read(8'hA0, 8'h0E, 32'h1122_0000, 2);
    rand_read(8'hA0, 8'h00, 32'h3344_0000, 2);

    // 4: sequential read wraps the full array 0x7FF -> 0x000
    write_txn(8'hAE, 8'hFF, 32'h7700_0000, 1, 1'b1);
    rand_read(8'hAE, 8'hFF, 32'h7733_4400, 3);

    // 5: ACK polling, write blocked while busy, wrong device type
    write_txn(8'hA0, 8'h20, 32'h9900_0000, 1, 1'b0);
    check("busy_during_poll", int'(busy), 1);
    i2c_start();
    tx(8'hA0, SDA_NACK, "poll_ctrl");
    tx(8'h20, SDA_NACK, "poll_addr");
    tx(8'h55, SDA_NACK, "poll_data");
    check("poll_wait_stop", int'(state_o), int'(ST_WAIT_STOP));
    i2c_stop();
    expect_val("busy_width", WR_CYCLES);
    wait_not_busy();
    rand_read(8'hA0, 8'h20, 32'h9900_0000, 1);

    i2c_start();
    tx(8'hB0, SDA_NACK, "bad_dev_ctrl");
    check("bad_dev_wait_stop", int'(state_o), int'(ST_WAIT_STOP));
    tx(8'h00, SDA_NACK, "bad_dev_data");
    check("bad_dev_still_wait", int'(state_o), int'(ST_WAIT_STOP));
    i2c_stop();
    check("bad_dev_idle", int'(state_o), int'(ST_IDLE));
    check("bad_dev_no_busy", int'(busy), 0);

    // 6: async reset while the slave drives a 0 data bit (mem[0x00E]=0x11)
    i2c_start();
    tx(8'hA0, SDA_ACK, "rst_ctrl_w");
    tx(8'h0E, SDA_ACK, "rst_addr");
    i2c_start();
    tx(8'hA1, SDA_ACK, "rst_ctrl_r");
    check("rdata_driving", int'(sda_oe), 1);
    check("rdata_state", int'(state_o), int'(ST_RDATA));
    #3 rst = 1'b1;
    #1;
    check("async_rst_oe", int'(sda_oe), 0);
    check("async_rst_state", int'(state_o), int'(ST_IDLE));
    #20 rst = 1'b0;
    @(negedge clk);
    m_scl = 1'b1;
    #(2*Q);
    i2c_start();
    tx(8'hA1, SDA_ACK, "post_rst_ctrl");
    rx(8'h33, SDA_NACK, "post_rst_data");
    i2c_stop();

    begin
      int k = 0;
      while ((exp_q.size() != 0 || obs_q.size() != 0) && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
